ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 27 ++
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester, RAM-port and status signals of the two-requester RAM read arbiter.
interface ram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic [1:0]    grant;
  logic          ram_req;
  logic [AW-1:0] ram_addr;
  logic          ram_ack;
  logic [DW-1:0] ram_rdata;
  logic          timeout_err;
  modport slave (
    input  req0, req1, addr0, addr1, ram_ack, ram_rdata,
    output ack0, ack1, rdata, grant, ram_req, ram_addr, timeout_err
  );
  modport master (
    output req0, req1, addr0, addr1, ram_ack, ram_rdata,
    input  ack0, ack1, rdata, grant, ram_req, ram_addr, timeout_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving two read requesters access to one RAM port.
// Define ARB_TIMEOUT_EN to force completion with 32'hDEADBEEF after TIMEOUT unacknowledged BUSY cycles.
module ram_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [1:0]    grant_q, grant_d;
  logic          ram_req_q, ram_req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;
  // on contention the requester not served last wins
  assign win = (bus_io.req0 & bus_io.req1) ? ~last_q : bus_io.req1;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          expire;
  assign expire = cnt_q == CW'(TIMEOUT - 1);
  assign bus_io.timeout_err = err_q;
`else
  assign bus_io.timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= '0;
      ram_req_q <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ram_req_q <= ram_req_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    ram_req_d = ram_req_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: if (bus_io.req0 | bus_io.req1) begin
        state_d   = BUSY;
        grant_d   = win ? 2'b10 : 2'b01;
        addr_d    = win ? bus_io.addr1 : bus_io.addr0;
        ram_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      BUSY: if (bus_io.ram_ack) begin
        state_d   = DONE;
        rdata_d   = bus_io.ram_rdata;
        ram_req_d = 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      else begin
        cnt_d = cnt_q + 1'b1;
        if (expire) begin
          state_d   = DONE;
          rdata_d   = DW'(32'hDEADBEEF);
          ram_req_d = 1'b0;
          err_d     = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        last_d  = grant_q[1];
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus_io.ack0     = (state_q == DONE) & grant_q[0];
  assign bus_io.ack1     = (state_q == DONE) & grant_q[1];
  assign bus_io.grant    = grant_q;
  assign bus_io.ram_req  = ram_req_q;
  assign bus_io.ram_addr = addr_q;
  assign bus_io.rdata    = rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with hand-computed expectations.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_ack0 = 0;
  int   n_ack1 = 0;
  int   n_both = 0;
  ram_arbiter_if #(.AW(8), .DW(32)) b ();
  ram_arbiter #(.AW(8), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus_io(b.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!reset) begin
    n_ack0 <= n_ack0 + int'(b.ack0);
    n_ack1 <= n_ack1 + int'(b.ack1);
    n_both <= n_both + int'(b.ack0 & b.ack1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic [1:0] g, input logic [7:0] a, input logic [31:0] d, input int w, input bit drop);
    tick;
    chk("grant", 64'(b.grant), 64'(g));
    chk("ram_req_on", 64'(b.ram_req), 64'd1);
    chk("ram_addr", 64'(b.ram_addr), 64'(a));
    if (drop) begin
      b.req0 = 1'b0;
      b.req1 = 1'b0;
    end
    for (int i = 0; i < w; i++) begin
      tick;
      chk("busy_req", 64'(b.ram_req), 64'd1);
      chk("busy_ack", 64'({b.ack1, b.ack0}), 64'd0);
    end
    b.ram_ack = 1'b1;
    b.ram_rdata = d;
    tick;
    chk("ack", 64'({b.ack1, b.ack0}), 64'(g));
    chk("rdata", 64'(b.rdata), 64'(d));
    chk("done_req", 64'(b.ram_req), 64'd0);
    b.ram_ack = 1'b0;
    b.ram_rdata = '0;
    tick;
    chk("ack_clear", 64'({b.ack1, b.ack0}), 64'd0);
    chk("idle_grant", 64'(b.grant), 64'd0);
    chk("rdata_hold", 64'(b.rdata), 64'(d));
  endtask
  initial begin
    reset = 1'b1;
    b.req0 = 1'b1;
    b.req1 = 1'b0;
    b.addr0 = 8'h00;
    b.addr1 = 8'h00;
    b.ram_ack = 1'b1;
    b.ram_rdata = 32'hFFFF_FFFF;
    tick;
    tick;
    chk("rst_ram_req", 64'(b.ram_req), 64'd0);
    chk("rst_ram_addr", 64'(b.ram_addr), 64'd0);
    chk("rst_acks", 64'({b.ack1, b.ack0}), 64'd0);
    chk("rst_rdata", 64'(b.rdata), 64'd0);
    chk("rst_grant", 64'(b.grant), 64'd0);
    chk("rst_terr", 64'(b.timeout_err), 64'd0);
    b.req0 = 1'b0;
    b.ram_rdata = 32'hCAFE_F00D;
    reset = 1'b0;
    tick;
    tick;
    chk("idle_ack_ign_grant", 64'(b.grant), 64'd0);
    chk("idle_ack_ign_ack", 64'({b.ack1, b.ack0}), 64'd0);
    chk("idle_ack_ign_rdata", 64'(b.rdata), 64'd0);
    b.ram_ack = 1'b0;
    b.req0 = 1'b1;
    b.addr0 = 8'h04;
    xfer(2'b01, 8'h04, 32'h1122_3344, 1, 1'b0);
    b.req0 = 1'b0;
    tick;
    chk("t1_no_regrant", 64'(b.grant), 64'd0);
    b.req1 = 1'b1;
    b.addr1 = 8'h20;
    xfer(2'b10, 8'h20, 32'h5566_7788, 0, 1'b0);
    b.req1 = 1'b0;
    tick;
    chk("t3_no_regrant", 64'(b.grant), 64'd0);
    chk("t3_idle_req", 64'(b.ram_req), 64'd0);
    b.req0 = 1'b1;
    b.addr0 = 8'h08;
    xfer(2'b01, 8'h08, 32'h0A0B_0C0D, 1, 1'b1);
    b.req1 = 1'b1;
    b.addr1 = 8'h30;
    tick;
    chk("abort_grant", 64'(b.grant), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("abort_ram_req", 64'(b.ram_req), 64'd0);
    chk("abort_grant0", 64'(b.grant), 64'd0);
    chk("abort_rdata", 64'(b.rdata), 64'd0);
    b.ram_ack = 1'b1;
    tick;
    tick;
    chk("abort_no_ack", 64'({b.ack1, b.ack0}), 64'd0);
    b.ram_ack = 1'b0;
    reset = 1'b0;
    b.req0 = 1'b1;
    b.addr0 = 8'h40;
    b.addr1 = 8'h44;
    xfer(2'b01, 8'h40, 32'h0000_0001, 0, 1'b0);
    xfer(2'b10, 8'h44, 32'h0000_0002, 2, 1'b0);
    xfer(2'b01, 8'h40, 32'h0000_0003, 0, 1'b0);
    xfer(2'b10, 8'h44, 32'h0000_0004, 0, 1'b0);
    b.req0 = 1'b0;
    b.req1 = 1'b0;
    tick;
    chk("rr_idle", 64'(b.grant), 64'd0);
    b.req0 = 1'b1;
    b.addr0 = 8'h50;
`ifdef ARB_TIMEOUT_EN
    tick;
    chk("to_grant", 64'(b.grant), 64'd1);
    b.req0 = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    chk("to_busy16_req", 64'(b.ram_req), 64'd1);
    chk("to_busy16_terr", 64'(b.timeout_err), 64'd0);
    tick;
    chk("to_ack", 64'({b.ack1, b.ack0}), 64'd1);
    chk("to_rdata", 64'(b.rdata), 64'hDEAD_BEEF);
    chk("to_terr", 64'(b.timeout_err), 64'd1);
    chk("to_ram_req", 64'(b.ram_req), 64'd0);
    tick;
    tick;
    chk("to_terr_sticky", 64'(b.timeout_err), 64'd1);
    reset = 1'b1;
    #1;
    chk("to_terr_rst", 64'(b.timeout_err), 64'd0);
    reset = 1'b0;
`else
    xfer(2'b01, 8'h50, 32'h0BAD_CAFE, 20, 1'b1);
    chk("no_to_terr", 64'(b.timeout_err), 64'd0);
`endif
    tick;
    chk("ack0_pulses", 64'(n_ack0), 64'd5);
    chk("ack1_pulses", 64'(n_ack1), 64'd3);
    chk("ack_both", 64'(n_both), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
